// File: rtl/mul_share_arb.sv
// mul_share_arb: round-robin arbiter sharing one pipelined N x N unsigned multiplier
// between two request ports; results return in accept order with a fixed 2-cycle latency.
module mul_share_arb #(
    parameter int N = 8
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           en,
    input  logic           req1_valid,
    output logic           req1_ready,
    input  logic [N-1:0]   a,
    input  logic [N-1:0]   b,
    input  logic           req2_valid,
    output logic           req2_ready,
    input  logic [N-1:0]   x,
    input  logic [N-1:0]   y,
    output logic [2*N-1:0] out1,
    output logic           out1_valid,
    output logic [2*N-1:0] out2,
    output logic           out2_valid
);
    logic           r_last;
    logic           r_s1_valid;
    logic           r_s1_tag;
    logic [N-1:0]   r_s1_a;
    logic [N-1:0]   r_s1_b;
    logic           w_acc;
    logic [2*N-1:0] w_prod;

    // r_last=1 means port 2 was granted last, so port 1 wins the next contention
    always_comb begin
        req1_ready = en && !rst && req1_valid && (!req2_valid || r_last);
        req2_ready = en && !rst && req2_valid && (!req1_valid || !r_last);
        w_acc      = req1_ready || req2_ready;
        w_prod     = {{N{1'b0}}, r_s1_a} * {{N{1'b0}}, r_s1_b};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_last     <= 1'b1;
            r_s1_valid <= 1'b0;
            r_s1_tag   <= 1'b0;
            r_s1_a     <= '0;
            r_s1_b     <= '0;
            out1       <= '0;
            out2       <= '0;
            out1_valid <= 1'b0;
            out2_valid <= 1'b0;
        end else begin
            out1_valid <= en && r_s1_valid && !r_s1_tag;
            out2_valid <= en && r_s1_valid && r_s1_tag;
            if (en) begin
                r_s1_valid <= w_acc;
                r_s1_tag   <= req2_ready;
                r_s1_a     <= req2_ready ? x : a;
                r_s1_b     <= req2_ready ? y : b;
                if (w_acc)
                    r_last <= req2_ready;
                if (r_s1_valid && !r_s1_tag)
                    out1 <= w_prod;
                if (r_s1_valid && r_s1_tag)
                    out2 <= w_prod;
            end
        end
    end
endmodule
